// File: rtl/spi_cmd_decoder_pkg.sv
// Shared constants, opcode encodings and frame-width helpers for the slot SPI command decoder.
// SPI_PARITY_EN adds one even-parity bit at the LSB of every frame.
package slot_spi_pkg;

    localparam int unsigned OP_W = 4;

`ifdef SPI_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    typedef enum logic [OP_W-1:0] {
        OP_SPIN   = 4'h1,
        OP_WIN    = 4'h2,
        OP_UPDATE = 4'h3
    } op_e;

    function automatic int unsigned payload_w(input int unsigned num_reels,
                                              input int unsigned reel_w,
                                              input int unsigned credit_w);
        int unsigned reel_bits;
        reel_bits = num_reels * reel_w;
        return (reel_bits > credit_w) ? reel_bits : credit_w;
    endfunction

    function automatic int unsigned frame_w(input int unsigned num_reels,
                                            input int unsigned reel_w,
                                            input int unsigned credit_w);
        return OP_W + payload_w(num_reels, reel_w, credit_w) + PARITY_BITS;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Bus bundle between the SPI host side and the command decoder.
// Widths follow the package frame-width helper, so SPI_PARITY_EN widens resp_word too.
interface spi_cmd_decoder_if
    import slot_spi_pkg::*;
#(
    parameter int unsigned NUM_REELS = 3,
    parameter int unsigned REEL_W    = 4,
    parameter int unsigned CREDIT_W  = 12
);
    localparam int unsigned FRAME_W = frame_w(NUM_REELS, REEL_W, CREDIT_W);

    logic                          cs_n;
    logic                          copi;
    logic                          sdo;
    logic [FRAME_W-1:0]            resp_word;
    logic [NUM_REELS*REEL_W-1:0]   reel_idx;
    logic                          start_spin;
    logic [CREDIT_W-1:0]           win_credits;
    logic                          is_win;
    logic [CREDIT_W-1:0]           total_credits;
    logic                          is_total;
    logic                          frame_err;
    logic                          op_err;
    logic                          parity_err;

    modport slave (
        input  cs_n, copi, resp_word,
        output sdo, reel_idx, start_spin, win_credits, is_win,
               total_credits, is_total, frame_err, op_err, parity_err
    );

    modport master (
        output cs_n, copi, resp_word,
        input  sdo, reel_idx, start_spin, win_credits, is_win,
               total_credits, is_total, frame_err, op_err, parity_err
    );

endinterface

// File: rtl/spi_shift_core.sv
// SPI framing core: bit counter, rx/tx shift registers, sdo mux, frame-complete and abort strobes.
// The strobes are combinational so the decoder can act on the very edge that samples the last bit.
module spi_shift_core #(
    parameter int unsigned FRAME_W = 16
) (
    input  logic               sclk,
    input  logic               reset_n,
    input  logic               i_cs_n,
    input  logic               i_copi,
    input  logic [FRAME_W-1:0] i_resp_word,
    output logic               o_sdo,
    output logic               o_frame_done,
    output logic               o_frame_abort,
    output logic [FRAME_W-1:0] o_frame
);
    localparam int unsigned CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-2:0] r_rx;
    logic [FRAME_W-1:0] r_tx;
    logic               w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_tx    <= '0;
        end else if (i_cs_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rx    <= '0;
            r_tx    <= '0;
        end else begin
            r_state <= ST_SHIFT;
            r_rx    <= {r_rx[FRAME_W-3:0], i_copi};
            r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            // MSB goes out combinationally at count 0, so the register keeps the rest
            r_tx    <= w_cnt_zero ? (i_resp_word << 1) : (r_tx << 1);
        end
    end

    assign o_frame       = {r_rx, i_copi};
    assign o_frame_done  = !i_cs_n && (r_cnt == LAST);
    assign o_frame_abort = i_cs_n && (r_state == ST_SHIFT) && !w_cnt_zero;
    assign o_sdo         = i_cs_n ? 1'b0
                         : (w_cnt_zero ? i_resp_word[FRAME_W-1] : r_tx[FRAME_W-1]);

endmodule

// File: rtl/spi_cmd_decoder.sv
// Slot-machine SPI command decoder: SPIN / WIN / UPDATE frames into held values plus one-cycle pulses.
// Define SPI_PARITY_EN to append an even-parity bit to each frame and report mismatches on parity_err.
module spi_cmd_decoder
    import slot_spi_pkg::*;
#(
    parameter int unsigned NUM_REELS = 3,
    parameter int unsigned REEL_W    = 4,
    parameter int unsigned CREDIT_W  = 12
) (
    input  logic               sclk,
    input  logic               reset_n,
    spi_cmd_decoder_if.slave   bus
);
    localparam int unsigned PAYLOAD_W = payload_w(NUM_REELS, REEL_W, CREDIT_W);
    localparam int unsigned FRAME_W   = frame_w(NUM_REELS, REEL_W, CREDIT_W);
    localparam int unsigned REEL_BITS = NUM_REELS * REEL_W;

    logic                 w_frame_done;
    logic                 w_frame_abort;
    logic [FRAME_W-1:0]   w_frame;
    logic [OP_W-1:0]      w_op;
    logic [PAYLOAD_W-1:0] w_payload;
    logic                 w_parity_ok;

    logic [REEL_BITS-1:0] r_reel_idx;
    logic [CREDIT_W-1:0]  r_win_credits;
    logic [CREDIT_W-1:0]  r_total_credits;
    logic                 r_start_spin;
    logic                 r_is_win;
    logic                 r_is_total;
    logic                 r_frame_err;
    logic                 r_op_err;

    spi_shift_core #(
        .FRAME_W (FRAME_W)
    ) u_core (
        .sclk          (sclk),
        .reset_n       (reset_n),
        .i_cs_n        (bus.cs_n),
        .i_copi        (bus.copi),
        .i_resp_word   (bus.resp_word),
        .o_sdo         (bus.sdo),
        .o_frame_done  (w_frame_done),
        .o_frame_abort (w_frame_abort),
        .o_frame       (w_frame)
    );

    assign w_op      = w_frame[FRAME_W-1 -: OP_W];
    assign w_payload = w_frame[PARITY_BITS +: PAYLOAD_W];

`ifdef SPI_PARITY_EN
    logic r_parity_err;

    assign w_parity_ok = ~(^w_frame);

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_frame_done && !w_parity_ok;
        end
    end

    assign bus.parity_err = r_parity_err;
`else
    assign w_parity_ok    = 1'b1;
    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_reel_idx      <= '0;
            r_win_credits   <= '0;
            r_total_credits <= '0;
            r_start_spin    <= 1'b0;
            r_is_win        <= 1'b0;
            r_is_total      <= 1'b0;
            r_frame_err     <= 1'b0;
            r_op_err        <= 1'b0;
        end else begin
            r_start_spin <= 1'b0;
            r_is_win     <= 1'b0;
            r_is_total   <= 1'b0;
            r_op_err     <= 1'b0;
            r_frame_err  <= w_frame_abort;
            // A parity failure suppresses decode entirely, keeping pulses mutually exclusive
            if (w_frame_done && w_parity_ok) begin
                case (op_e'(w_op))
                    OP_SPIN: begin
                        r_reel_idx   <= w_payload[REEL_BITS-1:0];
                        r_start_spin <= 1'b1;
                    end
                    OP_WIN: begin
                        r_win_credits <= w_payload[CREDIT_W-1:0];
                        r_is_win      <= 1'b1;
                    end
                    OP_UPDATE: begin
                        r_total_credits <= w_payload[CREDIT_W-1:0];
                        r_is_total      <= 1'b1;
                    end
                    default: r_op_err <= 1'b1;
                endcase
            end
        end
    end

    assign bus.reel_idx      = r_reel_idx;
    assign bus.win_credits   = r_win_credits;
    assign bus.total_credits = r_total_credits;
    assign bus.start_spin    = r_start_spin;
    assign bus.is_win        = r_is_win;
    assign bus.is_total      = r_is_total;
    assign bus.frame_err     = r_frame_err;
    assign bus.op_err        = r_op_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: stimulus queues expected pulses/sdo bits, a monitor compares.
// Build with SPI_PARITY_EN defined to add the parity-frame vectors.
module tb_spi_cmd_decoder;
    import slot_spi_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned FW = frame_w(NR, RW, CW);

    // pulse vector order: {start_spin, is_win, is_total, frame_err, op_err, parity_err}
    localparam logic [5:0] P_SPIN = 6'b100000;
    localparam logic [5:0] P_WIN  = 6'b010000;
    localparam logic [5:0] P_TOT  = 6'b001000;
    localparam logic [5:0] P_FERR = 6'b000100;
    localparam logic [5:0] P_OERR = 6'b000010;
    localparam logic [5:0] P_PERR = 6'b000001;

    typedef struct {
        string       name;
        logic [5:0]  pulses;
        logic [11:0] reel;
        logic [11:0] win;
        logic [11:0] tot;
    } exp_t;

    logic sclk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic sdo_q[$];

    always #5 sclk = ~sclk;

    spi_cmd_decoder_if #(.NUM_REELS(NR), .REEL_W(RW), .CREDIT_W(CW)) bus ();

    spi_cmd_decoder #(.NUM_REELS(NR), .REEL_W(RW), .CREDIT_W(CW)) dut (
        .sclk    (sclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [FW-1:0] frm(input logic [15:0] f);
`ifdef SPI_PARITY_EN
        return {f, ^f};
`else
        return f;
`endif
    endfunction

    function automatic void expect_ev(input string name, input logic [5:0] p,
                                      input logic [11:0] r, input logic [11:0] w, input logic [11:0] t);
        exp_t e;
        e.name = name; e.pulses = p; e.reel = r; e.win = w; e.tot = t;
        exp_q.push_back(e);
    endfunction

    task automatic send_bits(input logic [FW-1:0] f, input int unsigned nbits,
                             input bit chk_sdo, input logic [FW-1:0] resp);
        for (int unsigned i = 0; i < nbits; i++) begin
            @(negedge sclk);
            bus.cs_n = 1'b0;
            bus.copi = f[FW-1-i];
            if (chk_sdo) sdo_q.push_back(resp[FW-1-i]);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge sclk);
            bus.cs_n = 1'b1;
            bus.copi = 1'b0;
            sdo_q.push_back(1'b0);
        end
    endtask

    task automatic chk_held_zero(input string tag);
        chk({tag, "_reel"}, 32'(bus.reel_idx), 32'h0);
        chk({tag, "_win"}, 32'(bus.win_credits), 32'h0);
        chk({tag, "_tot"}, 32'(bus.total_credits), 32'h0);
        chk({tag, "_pulses"}, 32'({bus.start_spin, bus.is_win, bus.is_total,
                                   bus.frame_err, bus.op_err, bus.parity_err}), 32'h0);
        chk({tag, "_sdo"}, 32'(bus.sdo), 32'h0);
    endtask

    // Monitor: samples 2 time units after each negedge, well away from the active edge
    initial begin
        logic [5:0] pulses;
        logic       exp_sdo;
        exp_t       e;
        forever begin
            @(negedge sclk);
            #2;
            if (sdo_q.size() > 0) begin
                exp_sdo = sdo_q.pop_front();
                chk("sdo", 32'(bus.sdo), 32'(exp_sdo));
            end
            pulses = {bus.start_spin, bus.is_win, bus.is_total,
                      bus.frame_err, bus.op_err, bus.parity_err};
            if (pulses != 6'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got %b expected none", pulses);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_pulses"}, 32'(pulses), 32'(e.pulses));
                    chk({e.name, "_reel"}, 32'(bus.reel_idx), 32'(e.reel));
                    chk({e.name, "_win"}, 32'(bus.win_credits), 32'(e.win));
                    chk({e.name, "_tot"}, 32'(bus.total_credits), 32'(e.tot));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] resp;
        logic [FW-1:0] bad;

        reset_n       = 1'b0;
        bus.cs_n      = 1'b1;
        bus.copi      = 1'b0;
        bus.resp_word = '0;
        repeat (3) @(negedge sclk);
        chk_held_zero("reset");
        reset_n = 1'b1;
        idle(2);

        // Abort after 9 bits: frame_err, nothing decoded
        expect_ev("abort", P_FERR, 12'h000, 12'h000, 12'h000);
        send_bits(frm(16'h1ABC), 9, 1'b0, '0);
        idle(3);

        // SPIN with sdo response check
        resp = frm(16'hC3A5);
        bus.resp_word = resp;
        expect_ev("spin", P_SPIN, 12'h5A3, 12'h000, 12'h000);
        send_bits(frm(16'h15A3), FW, 1'b1, resp);
        idle(2);

        // Back-to-back WIN then UPDATE under one cs_n low
        expect_ev("win", P_WIN, 12'h5A3, 12'h064, 12'h000);
        expect_ev("total", P_TOT, 12'h5A3, 12'h064, 12'h0FF);
        send_bits(frm(16'h2064), FW, 1'b1, resp);
        send_bits(frm(16'h30FF), FW, 1'b1, resp);
        idle(2);

        // Unknown opcodes, including both ends of the opcode range
        expect_ev("op7", P_OERR, 12'h5A3, 12'h064, 12'h0FF);
        send_bits(frm(16'h7123), FW, 1'b0, resp);
        idle(2);
        expect_ev("op0", P_OERR, 12'h5A3, 12'h064, 12'h0FF);
        expect_ev("opF", P_OERR, 12'h5A3, 12'h064, 12'h0FF);
        send_bits(frm(16'h0FFF), FW, 1'b0, resp);
        send_bits(frm(16'hF001), FW, 1'b0, resp);
        idle(2);

`ifdef SPI_PARITY_EN
        bad = {16'h15A3, 1'b0};
        expect_ev("par_bad", P_PERR, 12'h5A3, 12'h064, 12'h0FF);
        send_bits(bad, FW, 1'b0, resp);
        idle(2);
        bad = {16'h1123, 1'b1};
        expect_ev("par_good", P_SPIN, 12'h123, 12'h064, 12'h0FF);
        send_bits(bad, FW, 1'b0, resp);
        idle(2);
`else
        bad = '0;
`endif

        // Reset in the middle of a frame: no pulse, everything cleared
        send_bits(frm(16'h1777), 8, 1'b0, resp);
        @(negedge sclk);
        reset_n  = 1'b0;
        bus.cs_n = 1'b1;
        bus.copi = 1'b0;
        #1;
        chk_held_zero("midreset");
        repeat (2) @(negedge sclk);
        reset_n = 1'b1;
        idle(4);
        chk_held_zero("after_reset");

        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
